eq_coeff_bank: RTL and testbench

- Double-buffered coefficient store that sits directly upstream of the equalizer and answers its eq_coeff_addr/eq_coeff lookup.
- The host writes single coefficients into a shadow bank, then commits. The banks swap only while the equalizer is between samples, so a sample is never processed with a half-updated set.
- After each swap the new active bank is copied back into the shadow bank, so later writes stay incremental.

---
 rtl/eq_coeff_bank.sv | 151 +++++++++++++++
 tb/tb_eq_coeff_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_bank.sv
// Double-buffered equalizer coefficient store: host writes the shadow bank, commit swaps banks
// between samples, then the new active bank is copied back into the shadow. Reads are zero latency.
module eq_coeff_bank #(
  parameter int NR_CHANNELS    = 4,
  parameter int NR_EQ_BANDS    = 8,
  parameter int EQ_COEFF_WIDTH = 32,
  localparam int N             = NR_CHANNELS * NR_EQ_BANDS * 5,
  localparam int AW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AW-1:0]             eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      eq_idle,
  input  logic [EQ_COEFF_WIDTH-1:0] wr_d,
  input  logic [AW-1:0]             wr_addr,
  input  logic                      wr_dv,
  output logic                      wr_dr,
  input  logic                      commit,
  output logic                      commit_pending,
  output logic                      bank,
  output logic                      addr_err
);

  localparam logic [EQ_COEFF_WIDTH-1:0] ONE =
    {3'b000, 1'b1, {(EQ_COEFF_WIDTH - 4){1'b0}}};
  localparam logic [AW:0]   N_LIM     = (AW + 1)'(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef logic [EQ_COEFF_WIDTH-1:0] word_t;
  typedef word_t mem_t [N];

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWAP_WAIT,
    S_COPY
  } state_t;

  // Pass-through biquads: a0 = 1.0, everything else zero.
  function automatic mem_t pass_through();
    mem_t m;
    for (int i = 0; i < N; i++) begin
      m[i] = ((i % 5) == 0) ? ONE : '0;
    end
    return m;
  endfunction

  // RAM contents and the bank select survive rst_n; only power-up sets them.
  mem_t   bank0_mem = pass_through();
  mem_t   bank1_mem = pass_through();
  logic   bank_q    = 1'b0;
  logic   bank_d;

  state_t          state_q, state_d;
  logic [AW-1:0]   copy_addr_q, copy_addr_d;
  logic            pending_q, pending_d;
  logic            addr_err_q, addr_err_d;

  logic            sh_we;
  logic [AW-1:0]   sh_addr;
  word_t           sh_dat;
  word_t           copy_rd;
  word_t           active_rd;
  logic            rd_in_range;
  logic            wr_in_range;

  assign rd_in_range = {1'b0, eq_coeff_addr} < N_LIM;
  assign wr_in_range = {1'b0, wr_addr} < N_LIM;

  assign active_rd = bank_q ? bank1_mem[eq_coeff_addr] : bank0_mem[eq_coeff_addr];
  assign copy_rd   = bank_q ? bank1_mem[copy_addr_q]   : bank0_mem[copy_addr_q];

  assign eq_coeff       = rd_in_range ? active_rd : '0;
  assign commit_pending = pending_q;
  assign bank           = bank_q;
  assign addr_err       = addr_err_q;

  always_comb begin
    state_d     = state_q;
    copy_addr_d = copy_addr_q;
    pending_d   = pending_q;
    addr_err_d  = 1'b0;
    bank_d      = bank_q;
    sh_we       = 1'b0;
    sh_addr     = wr_addr;
    sh_dat      = wr_d;
    wr_dr       = 1'b0;

    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          wr_dr = 1'b1;
          if (wr_dv) begin
            if (wr_in_range) sh_we      = 1'b1;
            else             addr_err_d = 1'b1;
          end
          // A write in the commit cycle lands in the shadow before the swap.
          if (commit) begin
            state_d   = S_SWAP_WAIT;
            pending_d = 1'b1;
          end
        end
        S_SWAP_WAIT: begin
          if (eq_idle) begin
            bank_d      = ~bank_q;
            copy_addr_d = '0;
            state_d     = S_COPY;
          end
        end
        S_COPY: begin
          sh_we       = 1'b1;
          sh_addr     = copy_addr_q;
          sh_dat      = copy_rd;
          copy_addr_d = copy_addr_q + AW'(1);
          if (copy_addr_q == LAST_ADDR) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_COPY;
          copy_addr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
    if (!rst_n) begin
      state_q     <= S_COPY;
      copy_addr_q <= '0;
      pending_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      copy_addr_q <= copy_addr_d;
      pending_q   <= pending_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // The shadow is always the bank not selected by bank_q.
  always_ff @(posedge clk) begin
    if (sh_we) begin
      if (bank_q) bank0_mem[sh_addr] <= sh_dat;
      else        bank1_mem[sh_addr] <= sh_dat;
    end
  end

endmodule

// File: tb/tb_eq_coeff_bank.sv
`timescale 1ns/1ps
module tb_eq_coeff_bank;

  localparam logic [31:0] ONE = 32'h1000_0000;
  localparam int SEL_COEFF = 0, SEL_WR_DR = 1, SEL_PEND = 2, SEL_BANK = 3, SEL_ERR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eq_coeff_addr = '0;
  logic [31:0] eq_coeff;
  logic        eq_idle = 1'b0;
  logic [31:0] wr_d = '0;
  logic [7:0]  wr_addr = '0;
  logic        wr_dv = 1'b0;
  logic        wr_dr;
  logic        commit = 1'b0;
  logic        commit_pending;
  logic        bank;
  logic        addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } chk_t;
  chk_t sb[$];

  eq_coeff_bank dut (
    .clk(clk), .rst_n(rst_n), .eq_coeff_addr(eq_coeff_addr), .eq_coeff(eq_coeff),
    .eq_idle(eq_idle), .wr_d(wr_d), .wr_addr(wr_addr), .wr_dv(wr_dv), .wr_dr(wr_dr),
    .commit(commit), .commit_pending(commit_pending), .bank(bank), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", n_chk, n_fail);
    $fatal(1);
  end

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin : monitor
    chk_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_COEFF: act = eq_coeff;
        SEL_WR_DR: act = {31'b0, wr_dr};
        SEL_PEND:  act = {31'b0, commit_pending};
        SEL_BANK:  act = {31'b0, bank};
        default:   act = {31'b0, addr_err};
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.nm, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input int sel, input logic [31:0] exp);
    chk_t e;
    e.nm = nm; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
    eq_coeff_addr = a;
    expect_val(nm, SEL_COEFF, exp);
    step();
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d, input logic cmt);
    wr_addr = a; wr_d = d; wr_dv = 1'b1; commit = cmt;
    step();
    wr_dv = 1'b0; commit = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!wr_dr && k < 400) begin
      step();
      k++;
    end
    if (!wr_dr) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: wr_dr still 0 after %0d cycles, expected 1", nm, k);
    end
  endtask

  task automatic check_copy_window(input string nm);
    for (int i = 0; i < 160; i++) begin
      expect_val(nm, SEL_WR_DR, 32'd0);
      step();
    end
    expect_val({nm, "_end"}, SEL_WR_DR, 32'd1);
  endtask

  initial begin
    // Power-up and reset
    step();
    step();
    expect_val("rst_pending", SEL_PEND, 32'd0);
    expect_val("rst_addr_err", SEL_ERR, 32'd0);
    expect_val("rst_wr_dr", SEL_WR_DR, 32'd0);
    expect_val("rst_bank", SEL_BANK, 32'd0);
    expect_val("rst_coeff0", SEL_COEFF, ONE);
    step();
    rst_n = 1'b1;
    check_copy_window("init_copy");
    rd("init_a0", 8'd0, ONE);
    rd("init_a1", 8'd1, 32'd0);
    expect_val("init_bank", SEL_BANK, 32'd0);

    // Shadow write without commit does not reach the active bank
    host_wr(8'd5, 32'h0800_0000, 1'b0);
    rd("shadow_hidden", 8'd5, ONE);
    expect_val("nocommit_bank", SEL_BANK, 32'd0);
    expect_val("nocommit_pend", SEL_PEND, 32'd0);

    // Commit held off by a busy equalizer; commit stays high to show it is not queued
    commit = 1'b1;
    eq_idle = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      expect_val("wait_bank", SEL_BANK, 32'd0);
      expect_val("wait_pend", SEL_PEND, 32'd1);
      expect_val("wait_wr_dr", SEL_WR_DR, 32'd0);
      if (i == 5) begin
        wr_addr = 8'd6; wr_d = 32'hDEAD_BEEF; wr_dv = 1'b1;
      end
      step();
      wr_dv = 1'b0;
    end
    eq_idle = 1'b1;
    step();
    eq_idle = 1'b0;
    eq_coeff_addr = 8'd5;
    expect_val("swap_bank", SEL_BANK, 32'd1);
    expect_val("swap_coeff5", SEL_COEFF, 32'h0800_0000);
    expect_val("swap_pend", SEL_PEND, 32'd1);
    step();
    rd("ignored_wr6", 8'd6, 32'd0);
    commit = 1'b0;
    repeat (157) step();
    expect_val("copy_last_wr_dr", SEL_WR_DR, 32'd0);
    expect_val("copy_last_pend", SEL_PEND, 32'd1);
    step();
    expect_val("copy_done_wr_dr", SEL_WR_DR, 32'd1);
    expect_val("copy_done_pend", SEL_PEND, 32'd0);

    // Coherence: write+commit in one cycle, swap back to bank 0
    eq_idle = 1'b1;
    host_wr(8'd6, 32'h0100_0000, 1'b1);
    step();
    eq_idle = 1'b0;
    expect_val("coh_bank", SEL_BANK, 32'd0);
    rd("coh_coeff5", 8'd5, 32'h0800_0000);
    rd("coh_coeff6", 8'd6, 32'h0100_0000);
    rd("coh_coeff0", 8'd0, ONE);
    wait_idle("coh_idle");
    expect_val("coh_pend", SEL_PEND, 32'd0);

    // Out-of-range write and read
    wr_addr = 8'd160; wr_d = 32'h1234_5678; wr_dv = 1'b1;
    expect_val("err_before", SEL_ERR, 32'd0);
    step();
    wr_dv = 1'b0;
    expect_val("err_pulse", SEL_ERR, 32'd1);
    step();
    expect_val("err_after", SEL_ERR, 32'd0);
    rd("oor_read", 8'd200, 32'd0);
    rd("oor_last_word", 8'd159, 32'd0);

    // Reset in the middle of a copy after swapping to bank 1
    eq_idle = 1'b1;
    host_wr(8'd159, 32'h0000_0ABC, 1'b1);
    step();
    eq_idle = 1'b0;
    expect_val("mid_bank", SEL_BANK, 32'd1);
    repeat (50) step();
    rst_n = 1'b0;
    step();
    expect_val("mid_rst_bank", SEL_BANK, 32'd1);
    expect_val("mid_rst_pend", SEL_PEND, 32'd0);
    expect_val("mid_rst_wr_dr", SEL_WR_DR, 32'd0);
    step();
    rst_n = 1'b1;
    check_copy_window("recopy");
    expect_val("recopy_pend", SEL_PEND, 32'd0);
    rd("rst_keep5", 8'd5, 32'h0800_0000);
    rd("rst_keep6", 8'd6, 32'h0100_0000);
    rd("rst_keep159", 8'd159, 32'h0000_0ABC);
    rd("rst_keep0", 8'd0, ONE);
    rd("rst_keep1", 8'd1, 32'd0);

    eq_idle = 1'b1;
    host_wr(8'd10, 32'h0000_0777, 1'b1);
    step();
    eq_idle = 1'b0;
    wait_idle("post_idle");
    expect_val("post_bank", SEL_BANK, 32'd0);
    rd("post_coeff10", 8'd10, 32'h0000_0777);
    rd("post_coeff5", 8'd5, 32'h0800_0000);
    rd("post_coeff6", 8'd6, 32'h0100_0000);
    rd("post_coeff159", 8'd159, 32'h0000_0ABC);
    rd("post_coeff0", 8'd0, ONE);
    rd("post_coeff1", 8'd1, 32'd0);

    step();
    step();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
